// File: rtl/scroll_scheduler_pkg.sv
// Shared definitions for the scroll scheduler: sequencer state encoding,
// default level/screen geometry and the derived right-hand scroll limit.
package scroll_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        UPDATE    = 3'd1,
        START_BG  = 3'd2,
        WAIT_BG   = 3'd3,
        START_SPR = 3'd4,
        WAIT_SPR  = 3'd5
    } sched_state_t;

    // Default geometry: 2000-tile level, 20 x 15 visible tiles of 8 x 8 pixels.
    localparam int TILEMAP_TILES  = 2000;
    localparam int SCREEN_TILES_X = 20;
    localparam int SCREEN_TILES_Y = 15;
    localparam int TILE_PX        = 8;

    // Last column that still leaves a full screen of tiles to the right.
    localparam int MAX_OFFSET = TILEMAP_TILES - SCREEN_TILES_X;

endpackage

// File: rtl/scroll_offset_counter.sv
// Saturating up/down tile-column counter holding the first visible column.
// Moves by one per enabled step, clamps at 0 and MAX_VAL, never wraps.
module scroll_offset_counter
    import scroll_scheduler_pkg::*;
#(
    parameter int OFFSET_W = 11,
    parameter int MAX_VAL  = MAX_OFFSET
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                step_en,
    input  logic                up,
    input  logic                down,
    output logic [OFFSET_W-1:0] x_offset
);

    localparam logic [OFFSET_W-1:0] LIMIT = OFFSET_W'(MAX_VAL);

    logic [OFFSET_W-1:0] x_offset_q;
    logic [OFFSET_W-1:0] x_offset_d;

    // Next column: single-direction requests move one tile unless at a limit.
    always_comb begin
        x_offset_d = x_offset_q;
        if (step_en) begin
            if (up && !down && (x_offset_q < LIMIT)) begin
                x_offset_d = x_offset_q + OFFSET_W'(1);
            end else if (down && !up && (x_offset_q != '0)) begin
                x_offset_d = x_offset_q - OFFSET_W'(1);
            end
        end
    end

    // Column register, cleared to the left edge of the level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_offset_q <= '0;
        end else begin
            x_offset_q <= x_offset_d;
        end
    end

    assign x_offset = x_offset_q;

endmodule

// File: rtl/scroll_scheduler.sv
// Per-frame sequencer upstream of the background drawer. Each accepted
// frame tick advances a frame divider (one scroll step every FRAME_DIV
// frames), then starts the background drawer, waits for it, starts the
// sprite drawer and waits for it. The column offset only moves on the
// UPDATE -> START_BG edge, so it is frozen while either drawer runs.
// Ticks arriving while a frame is in progress are dropped.
// Optional: SCROLL_SCHED_OVERRUN_CNT_EN adds an 8-bit saturating count
// of dropped ticks on overrun_count.
module scroll_scheduler
    import scroll_scheduler_pkg::*;
#(
    parameter int TILEMAP_LENGTH = TILEMAP_TILES,
    parameter int SCREEN_TILES   = SCREEN_TILES_X,
    parameter int FRAME_DIV      = 4,
    parameter int OFFSET_W       = 11
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                frame_tick,
    input  logic                scroll_right,
    input  logic                scroll_left,
    output logic [OFFSET_W-1:0] x_offset,
    output logic                bg_enable,
    input  logic                bg_done,
    output logic                spr_enable,
    input  logic                spr_done,
`ifdef SCROLL_SCHED_OVERRUN_CNT_EN
    output logic [7:0]          overrun_count,
`endif
    output logic                busy
);

    localparam int MAX_OFF = TILEMAP_LENGTH - SCREEN_TILES;
    localparam int DIV_W   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

    sched_state_t     state_q;
    logic [DIV_W-1:0] div_q;
    logic             bg_enable_q;
    logic             spr_enable_q;
    logic             busy_q;
    logic             step_en;

    // Scroll requests only matter in the UPDATE cycle of the last divided frame.
    assign step_en = (state_q == UPDATE) && (div_q == DIV_LAST);

    scroll_offset_counter #(
        .OFFSET_W (OFFSET_W),
        .MAX_VAL  (MAX_OFF)
    ) u_offset (
        .clock    (clock),
        .reset    (reset),
        .step_en  (step_en),
        .up       (scroll_right),
        .down     (scroll_left),
        .x_offset (x_offset)
    );

    // Frame sequencer with divider and registered enable/busy outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            div_q        <= '0;
            bg_enable_q  <= 1'b0;
            spr_enable_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            bg_enable_q  <= 1'b0;
            spr_enable_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (frame_tick) begin
                        state_q <= UPDATE;
                        busy_q  <= 1'b1;
                    end
                end
                UPDATE: begin
                    div_q       <= (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
                    state_q     <= START_BG;
                    bg_enable_q <= 1'b1;
                end
                START_BG: begin
                    state_q <= WAIT_BG;
                end
                WAIT_BG: begin
                    if (bg_done) begin
                        state_q      <= START_SPR;
                        spr_enable_q <= 1'b1;
                    end
                end
                START_SPR: begin
                    state_q <= WAIT_SPR;
                end
                WAIT_SPR: begin
                    if (spr_done) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SCROLL_SCHED_OVERRUN_CNT_EN
    logic [7:0] overrun_q;

    // Count ticks that arrive while a frame is still in progress.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overrun_q <= '0;
        end else if (frame_tick && (state_q != IDLE) && (overrun_q != 8'hFF)) begin
            overrun_q <= overrun_q + 8'd1;
        end
    end

    assign overrun_count = overrun_q;
`endif

    assign bg_enable  = bg_enable_q;
    assign spr_enable = spr_enable_q;
    assign busy       = busy_q;

endmodule
